lcd_ctrl: RTL

//  Memory-mapped responder on the core's load/store bus (addr, store data, write enable, load data).

---
 rtl/lcd_ctrl_if.sv | 29 ++
 rtl/lcd_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// lcd_ctrl_if : load/store bus port of the LCD controller register block
// Rev 1.0 - initial release
// ============================================================================
interface lcd_ctrl_if;
   logic [31:0] lsu_addr;
   logic [31:0] st_data;
   logic        lsu_wren;
   logic [31:0] ld_data;
   logic        hit;

   modport master (
      output lsu_addr,
      output st_data,
      output lsu_wren,
      input  ld_data,
      input  hit
   );

   modport slave (
      input  lsu_addr,
      input  st_data,
      input  lsu_wren,
      output ld_data,
      output hit
   );
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// lcd_ctrl : memory-mapped HD44780 write engine with command FIFO and
//            hardware EN setup/pulse/hold and execution-time sequencing
// Rev 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h7040,
   parameter int          FIFO_DEPTH = 4,
   parameter int          T_SETUP    = 2,
   parameter int          T_PW       = 12,
   parameter int          T_HOLD     = 2,
   parameter int          T_EXEC     = 2000,
   parameter int          T_LONG     = 82000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   lcd_ctrl_if.slave  lsu_bus,
   output logic       o_lcd_on,
   output logic       o_lcd_en,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic [7:0] o_lcd_data
);

   localparam int c_AW    = $clog2(FIFO_DEPTH);
   localparam int c_MAX_A = (T_LONG > T_EXEC) ? T_LONG : T_EXEC;
   localparam int c_MAX_B = (T_PW > T_SETUP) ? T_PW : T_SETUP;
   localparam int c_MAX_C = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
   localparam int c_MAX   = (c_MAX_C > T_HOLD) ? c_MAX_C : T_HOLD;
   localparam int c_CNT_W = ($clog2(c_MAX) < 1) ? 1 : $clog2(c_MAX);

   localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(T_SETUP - 1);
   localparam logic [c_CNT_W-1:0] c_LD_PW    = c_CNT_W'(T_PW - 1);
   localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(T_HOLD - 1);
   localparam logic [c_CNT_W-1:0] c_LD_EXEC  = c_CNT_W'(T_EXEC - 1);
   localparam logic [c_CNT_W-1:0] c_LD_LONG  = c_CNT_W'(T_LONG - 1);
   localparam logic [c_AW:0]      c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_WAIT  = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [8:0]           r_fifo [FIFO_DEPTH];
   logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [c_AW:0]        r_count;
   logic [8:0]           r_cur;
   logic                 r_lcd_en, r_ovf, r_on;
   logic                 w_hit, w_data_wr, w_ctrl_wr, w_full, w_empty;
   logic                 w_push, w_pop, w_long, w_busy;
   logic [3:0]           w_count4;
   logic                 w_unused_bits;

   assign w_hit     = (lsu_bus.lsu_addr[31:3] == BASE_ADDR[31:3]);
   assign w_data_wr = w_hit && lsu_bus.lsu_wren && !lsu_bus.lsu_addr[2];
   assign w_ctrl_wr = w_hit && lsu_bus.lsu_wren &&  lsu_bus.lsu_addr[2];
   assign w_full    = (r_count == c_DEPTH);
   assign w_empty   = (r_count == '0);
   // A pop on the same edge frees the slot, so a full FIFO still accepts the write
   assign w_push    = w_data_wr && (!w_full || w_pop);
   assign w_long    = !r_cur[8] && ((r_cur[7:0] == 8'h01) || (r_cur[7:0] == 8'h02) ||
                                    (r_cur[7:0] == 8'h03));
   assign w_busy    = (r_state != S_IDLE) || !w_empty;
   assign w_count4  = 4'(r_count);
   assign w_unused_bits = ^{lsu_bus.st_data[31:9], lsu_bus.lsu_addr[1:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_cnt_nxt   = c_LD_SETUP;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_cnt == '0) begin
               w_cnt_nxt   = c_LD_PW;
               w_state_nxt = S_PULSE;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         S_PULSE: begin
            if (r_cnt == '0) begin
               w_cnt_nxt   = c_LD_HOLD;
               w_state_nxt = S_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_cnt_nxt   = w_long ? c_LD_LONG : c_LD_EXEC;
               w_state_nxt = S_WAIT;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_lcd_en <= 1'b0;
         r_cur    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_lcd_en <= (w_state_nxt == S_PULSE);
         if (w_pop) begin
            r_cur <= r_fifo[r_rd_ptr];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_on     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (c_AW + 1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (c_AW + 1)'(1);
         end
         if (w_ctrl_wr && lsu_bus.st_data[1]) begin
            r_ovf <= 1'b0;
         end else if (w_data_wr && !w_push) begin
            r_ovf <= 1'b1;
         end
         if (w_ctrl_wr) begin
            r_on <= lsu_bus.st_data[0];
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= lsu_bus.st_data[8:0];
      end
   end

   always_comb begin
      lsu_bus.ld_data = '0;
      if (w_hit) begin
         if (lsu_bus.lsu_addr[2]) begin
            lsu_bus.ld_data = {30'b0, r_ovf, r_on};
         end else begin
            lsu_bus.ld_data = {24'b0, w_count4, 1'b0, r_ovf, w_full, w_busy};
         end
      end
   end

   assign lsu_bus.hit = w_hit;
   assign o_lcd_on    = r_on;
   assign o_lcd_en    = r_lcd_en;
   assign o_lcd_rs    = r_cur[8];
   assign o_lcd_data  = r_cur[7:0];
   assign o_lcd_rw    = 1'b0;

endmodule
`default_nettype wire
